alu_req_issuer: RTL and testbench

ALU_REQ_ISSUER -- requirements
Module: alu_req_issuer

---
 rtl/alu_req_issuer_if.sv | 46 ++++
 rtl/alu_req_issuer.sv | 114 +++++++++++
 tb/tb_alu_req_issuer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_req_issuer_if.sv
//------------------------------------------------------------------------------
// Module   : alu_req_issuer_if
// Brief    : Request, ALU and response signal bundle for alu_req_issuer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface alu_req_issuer_if #(
  parameter int CNT_W = 16
);
  logic             req_valid_i;
  logic             req_ready_o;
  logic [5:0]       req_op_i;
  logic [5:0]       req_funct_i;
  logic [31:0]      req_src1_i;
  logic [31:0]      req_src2_i;
  logic [31:0]      alu_src1_o;
  logic [31:0]      alu_src2_o;
  logic [3:0]       alu_ctrl_o;
  logic [31:0]      alu_result_i;
  logic             alu_zero_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [31:0]      rsp_result_o;
  logic             rsp_zero_o;
  logic             rsp_err_o;
  logic [CNT_W-1:0] op_cnt_o;

  // Issuer side
  modport slave (
    input  req_valid_i, req_op_i, req_funct_i, req_src1_i, req_src2_i,
    input  alu_result_i, alu_zero_i, rsp_ready_i,
    output req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
    output rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_err_o, op_cnt_o
  );

  // Requester / consumer / ALU side
  modport master (
    output req_valid_i, req_op_i, req_funct_i, req_src1_i, req_src2_i,
    output alu_result_i, alu_zero_i, rsp_ready_i,
    input  req_ready_o, alu_src1_o, alu_src2_o, alu_ctrl_o,
    input  rsp_valid_o, rsp_result_o, rsp_zero_o, rsp_err_o, op_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_req_issuer.sv
//------------------------------------------------------------------------------
// Module   : alu_req_issuer
// Brief    : Decodes MIPS ALU requests, drives an external ALU for one cycle
//            and returns the captured result through a valid/ready response.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module alu_req_issuer #(
  parameter int CNT_W = 16
) (
  input  wire logic         clk_i,
  input  wire logic         rst_i,
  alu_req_issuer_if.slave   bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_RESP  = 2'd2;

  logic [1:0]       r_state;
  logic [31:0]      r_src1;
  logic [31:0]      r_src2;
  logic [3:0]       r_ctrl;
  logic [31:0]      r_result;
  logic             r_zero;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic             w_legal;
  logic [3:0]       w_ctrl;

  always_comb begin
    w_legal = 1'b0;
    w_ctrl  = 4'b0000;
    unique case (bus.req_op_i)
      6'b000000: begin
        w_legal = 1'b1;
        unique case (bus.req_funct_i)
          6'b100100: w_ctrl = 4'b0000;
          6'b100101: w_ctrl = 4'b0001;
          6'b100000: w_ctrl = 4'b0010;
          6'b100010: w_ctrl = 4'b0110;
          6'b101010: w_ctrl = 4'b0111;
          default:   w_legal = 1'b0;
        endcase
      end
      6'b001000: begin w_legal = 1'b1; w_ctrl = 4'b0010; end
      6'b001010: begin w_legal = 1'b1; w_ctrl = 4'b0111; end
      6'b000100: begin w_legal = 1'b1; w_ctrl = 4'b0110; end
      default:   w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= c_IDLE;
      r_src1   <= '0;
      r_src2   <= '0;
      r_ctrl   <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        c_IDLE: begin
          if (bus.req_valid_i) begin
            if (w_legal) begin
              r_src1  <= bus.req_src1_i;
              r_src2  <= bus.req_src2_i;
              r_ctrl  <= w_ctrl;
              r_state <= c_ISSUE;
            end else begin
              // Undecodable requests bypass the ALU and answer with an error
              r_result <= '0;
              r_zero   <= 1'b0;
              r_err    <= 1'b1;
              r_state  <= c_RESP;
            end
          end
        end
        c_ISSUE: begin
          r_result <= bus.alu_result_i;
          r_zero   <= bus.alu_zero_i;
          r_err    <= 1'b0;
          r_state  <= c_RESP;
        end
        c_RESP: begin
          if (bus.rsp_ready_i) begin
            if (!r_err) r_cnt <= r_cnt + 1'b1;
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // ALU inputs are only exposed while the operation is in flight
  assign bus.alu_src1_o   = (r_state == c_ISSUE) ? r_src1 : 32'd0;
  assign bus.alu_src2_o   = (r_state == c_ISSUE) ? r_src2 : 32'd0;
  assign bus.alu_ctrl_o   = (r_state == c_ISSUE) ? r_ctrl : 4'b0000;

  assign bus.req_ready_o  = (r_state == c_IDLE);
  assign bus.rsp_valid_o  = (r_state == c_RESP);
  assign bus.rsp_result_o = r_result;
  assign bus.rsp_zero_o   = r_zero;
  assign bus.rsp_err_o    = r_err;
  assign bus.op_cnt_o     = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_alu_req_issuer.sv
//------------------------------------------------------------------------------
// Module   : tb_alu_req_issuer
// Brief    : Directed self-checking bench for alu_req_issuer with an ALU model.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_alu_req_issuer;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  always #5 clk_i = ~clk_i;

  alu_req_issuer_if #(.CNT_W(16)) bus  ();
  alu_req_issuer_if #(.CNT_W(2))  bus2 ();

  alu_req_issuer #(.CNT_W(16)) u_dut  (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));
  alu_req_issuer #(.CNT_W(2))  u_dut2 (.clk_i(clk_i), .rst_i(rst_i), .bus(bus2));

  function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a,
                                        input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign bus.alu_result_i  = alu_f(bus.alu_ctrl_o, bus.alu_src1_o, bus.alu_src2_o);
  assign bus.alu_zero_i    = (bus.alu_result_i == 32'd0);
  assign bus2.alu_result_i = alu_f(bus2.alu_ctrl_o, bus2.alu_src1_o, bus2.alu_src2_o);
  assign bus2.alu_zero_i   = (bus2.alu_result_i == 32'd0);

  // Second instance sees the same request stream as the first
  assign bus2.req_valid_i = bus.req_valid_i;
  assign bus2.req_op_i    = bus.req_op_i;
  assign bus2.req_funct_i = bus.req_funct_i;
  assign bus2.req_src1_i  = bus.req_src1_i;
  assign bus2.req_src2_i  = bus.req_src2_i;
  assign bus2.rsp_ready_i = bus.rsp_ready_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_op(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] e_ctrl, input logic [31:0] e_res,
                       input logic e_zero, input logic e_err);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_funct_i = fn;
    bus.req_src1_i  = a;
    bus.req_src2_i  = b;
    tick();
    bus.req_valid_i = 1'b0;
    if (!e_err) begin
      check({tag, "_ctrl"},  {28'd0, bus.alu_ctrl_o}, {28'd0, e_ctrl});
      check({tag, "_early"}, {31'd0, bus.rsp_valid_o}, 32'd0);
      tick();
    end else begin
      check({tag, "_ctrl0"}, {28'd0, bus.alu_ctrl_o}, 32'd0);
    end
    check({tag, "_valid"}, {31'd0, bus.rsp_valid_o}, 32'd1);
    check({tag, "_res"},   bus.rsp_result_o, e_res);
    check({tag, "_zero"},  {31'd0, bus.rsp_zero_o}, {31'd0, e_zero});
    check({tag, "_err"},   {31'd0, bus.rsp_err_o}, {31'd0, e_err});
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.rsp_ready_i = 1'b0;
    if (!e_err) exp_cnt++;
    check({tag, "_ready"}, {31'd0, bus.req_ready_o}, 32'd1);
    check({tag, "_cnt"},   {16'd0, bus.op_cnt_o}, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold_res;
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = '0;
    bus.req_funct_i = '0;
    bus.req_src1_i  = '0;
    bus.req_src2_i  = '0;
    bus.rsp_ready_i = 1'b0;
    #23 rst_i = 1'b1;
    tick();
    check("rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check("rst_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("rst_cnt",   {16'd0, bus.op_cnt_o}, 32'd0);
    check("rst_ctrl",  {28'd0, bus.alu_ctrl_o}, 32'd0);

    do_op("add",  6'b000000, 6'b100000, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0);
    do_op("beq",  6'b000100, 6'b000000, 32'h1234, 32'h1234, 4'b0110, 32'd0, 1'b1, 1'b0);
    do_op("slti", 6'b001010, 6'b000000, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0);
    do_op("bad",  6'b111111, 6'b000000, 32'd9, 32'd9, 4'b0000, 32'd0, 1'b0, 1'b1);
    do_op("and",  6'b000000, 6'b100100, 32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b0000,
          32'h00F0_F000, 1'b0, 1'b0);
    do_op("or",   6'b000000, 6'b100101, 32'hF0F0_FF00, 32'h0FF0_F0F0, 4'b0001,
          32'hFFF0_FFF0, 1'b0, 1'b0);
    do_op("sub",  6'b000000, 6'b100010, 32'd10, 32'd3, 4'b0110, 32'd7, 1'b0, 1'b0);
    do_op("slt",  6'b000000, 6'b101010, 32'd3, 32'hFFFF_FFFB, 4'b0111, 32'd0, 1'b1, 1'b0);
    do_op("addi", 6'b001000, 6'b000000, 32'hFFFF_FFFF, 32'd2, 4'b0010, 32'd1, 1'b0, 1'b0);
    do_op("badfn", 6'b000000, 6'b000000, 32'd1, 32'd1, 4'b0000, 32'd0, 1'b0, 1'b1);

    // Stall in RESP while request inputs churn
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 6'b000000;
    bus.req_funct_i = 6'b100000;
    bus.req_src1_i  = 32'd100;
    bus.req_src2_i  = 32'd23;
    tick();
    tick();
    hold_res = bus.rsp_result_o;
    check("stall_res0", hold_res, 32'd123);
    for (int i = 0; i < 5; i++) begin
      bus.req_valid_i = i[0];
      bus.req_op_i    = 6'($urandom);
      bus.req_funct_i = 6'($urandom);
      bus.req_src1_i  = $urandom;
      bus.req_src2_i  = $urandom;
      tick();
      check("stall_valid", {31'd0, bus.rsp_valid_o}, 32'd1);
      check("stall_rdy",   {31'd0, bus.req_ready_o}, 32'd0);
      check("stall_res",   bus.rsp_result_o, 32'd123);
      check("stall_err",   {31'd0, bus.rsp_err_o}, 32'd0);
    end
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 6'b000000;
    bus.req_funct_i = 6'b100000;
    bus.rsp_ready_i = 1'b1;
    tick();
    bus.req_valid_i = 1'b0;
    bus.rsp_ready_i = 1'b0;
    exp_cnt++;
    check("stall_idle", {31'd0, bus.req_ready_o}, 32'd1);
    check("stall_done", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("stall_cnt",  {16'd0, bus.op_cnt_o}, exp_cnt);
    tick();
    check("no_accept",  {31'd0, bus.req_ready_o}, 32'd1);

    // Asynchronous reset while in ISSUE
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 6'b000000;
    bus.req_funct_i = 6'b100000;
    bus.req_src1_i  = 32'd1;
    bus.req_src2_i  = 32'd2;
    tick();
    bus.req_valid_i = 1'b0;
    check("pre_rst_ctrl", {28'd0, bus.alu_ctrl_o}, 32'd2);
    #2 rst_i = 1'b0;
    #1;
    check("arst_ctrl",  {28'd0, bus.alu_ctrl_o}, 32'd0);
    check("arst_src1",  bus.alu_src1_o, 32'd0);
    check("arst_valid", {31'd0, bus.rsp_valid_o}, 32'd0);
    check("arst_cnt",   {16'd0, bus.op_cnt_o}, 32'd0);
    check("arst_res",   bus.rsp_result_o, 32'd0);
    #13 rst_i = 1'b1;
    exp_cnt = 0;
    tick();
    tick();
    check("post_rst_ready", {31'd0, bus.req_ready_o}, 32'd1);
    check("post_rst_valid", {31'd0, bus.rsp_valid_o}, 32'd0);

    // Narrow counter wraps: 1,2,3,0,1
    for (int i = 0; i < 5; i++) begin
      do_op("wrap", 6'b001000, 6'b000000, i, 32'd1, 4'b0010, i + 1, 1'b0, 1'b0);
      check("wrap_cnt2", {30'd0, bus2.op_cnt_o}, (i + 1) % 4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
